shift_deserializer: RTL and testbench

Serial-in, parallel-out receiver for the bit stream produced by the team's parallel-load shift register. It is the far end of that link. It samples one bit per enabled clock, assembles SHIFT_WIDTH-bit words in the same bit order the transmitter shifts them out, and presents each completed word on a one-deep valid/ready output register. Words that complete while the output register is still occupied are dropped, and a sticky overflow flag is set.

---
 rtl/shift_deserializer_if.sv | 25 ++
 rtl/shift_deserializer.sv | 79 +++++++
 tb/tb_shift_deserializer.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/shift_deserializer_if.sv
// Handshake and data bundle between the serial bit source, the deserializer and the word consumer.
interface shift_deserializer_if #(
  parameter int W  = 8,
  parameter int CW = $clog2(W)
);
  logic          enable;
  logic          shiftin;
  logic          restart;
  logic [W-1:0]  q;
  logic          q_valid;
  logic          q_ready;
  logic          overflow;
  logic          ovf_clr;
  logic [CW-1:0] bit_count;

  modport master (
    output enable, shiftin, restart, q_ready, ovf_clr,
    input  q, q_valid, overflow, bit_count
  );

  modport slave (
    input  enable, shiftin, restart, q_ready, ovf_clr,
    output q, q_valid, overflow, bit_count
  );
endinterface

// File: rtl/shift_deserializer.sv
// Serial-in/parallel-out receiver: assembles SHIFT_WIDTH-bit words and presents them on a
// one-deep valid/ready register; words completing while that register is full are dropped.
module shift_deserializer #(
  parameter int SHIFT_WIDTH     = 8,
  parameter     SHIFT_DIRECTION = "LEFT",
  parameter int CW              = $clog2(SHIFT_WIDTH)
) (
  input logic                 clock,
  input logic                 sclr,
  shift_deserializer_if.slave bus
);
  localparam bit            IS_LEFT = (SHIFT_DIRECTION == "LEFT");
  localparam logic [CW-1:0] LAST    = CW'(SHIFT_WIDTH - 1);

  logic [SHIFT_WIDTH-1:0] sreg_q, sreg_d, shifted;
  logic [SHIFT_WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   qv_q, qv_d;
  logic                   ovf_q, ovf_d;
  logic                   complete;

  always_comb begin
    sreg_d   = sreg_q;
    cnt_d    = cnt_q;
    q_d      = q_q;
    qv_d     = qv_q;
    ovf_d    = ovf_q;
    complete = 1'b0;
    shifted  = IS_LEFT ? {sreg_q[SHIFT_WIDTH-2:0], bus.shiftin}
                       : {bus.shiftin, sreg_q[SHIFT_WIDTH-1:1]};

    if (bus.restart) begin
      sreg_d = '0;
      cnt_d  = '0;
    end else if (bus.enable) begin
      sreg_d = shifted;
      if (cnt_q == LAST) begin
        cnt_d    = '0;
        complete = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    // Output-register handling runs regardless of restart; a drop beats ovf_clr.
    if (bus.ovf_clr) ovf_d = 1'b0;
    if (complete) begin
      if (!qv_q || bus.q_ready) begin
        q_d  = shifted;
        qv_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (qv_q && bus.q_ready) begin
      qv_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (sclr) begin
      sreg_q <= '0;
      cnt_q  <= '0;
      q_q    <= '0;
      qv_q   <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      sreg_q <= sreg_d;
      cnt_q  <= cnt_d;
      q_q    <= q_d;
      qv_q   <= qv_d;
      ovf_q  <= ovf_d;
    end
  end

  assign bus.q         = q_q;
  assign bus.q_valid   = qv_q;
  assign bus.overflow  = ovf_q;
  assign bus.bit_count = cnt_q;
endmodule

// File: tb/tb_shift_deserializer.sv
// Drives a LEFT and a RIGHT deserializer with the same serial stream and checks both against
// a word-level model every cycle, plus literal expectations at key points.
module tb_shift_deserializer;
  localparam int W = 8;

  logic clock = 1'b0;
  logic sclr = 1'b0;
  logic en = 1'b0, sin = 1'b0, rs = 1'b0, rdy = 1'b0, oc = 1'b0;
  int   total = 0;
  int   bad = 0;
  bit   checking = 1'b0;

  always #5 clock = ~clock;

  shift_deserializer_if #(.W(W)) bl ();
  shift_deserializer_if #(.W(W)) br ();

  assign bl.enable = en;  assign bl.shiftin = sin; assign bl.restart = rs;
  assign bl.q_ready = rdy; assign bl.ovf_clr = oc;
  assign br.enable = en;  assign br.shiftin = sin; assign br.restart = rs;
  assign br.q_ready = rdy; assign br.ovf_clr = oc;

  shift_deserializer #(.SHIFT_WIDTH(W), .SHIFT_DIRECTION("LEFT"))  u_left  (.clock(clock), .sclr(sclr), .bus(bl));
  shift_deserializer #(.SHIFT_WIDTH(W), .SHIFT_DIRECTION("RIGHT")) u_right (.clock(clock), .sclr(sclr), .bus(br));

  // Word-level model: partial word kept as a list of received bits.
  bit         m_bits[$];
  logic [7:0] m_ql = '0, m_qr = '0;
  bit         m_qv = 1'b0, m_ovf = 1'b0;

  always @(posedge clock) begin
    bit done;
    logic [7:0] wl, wr;
    done = 1'b0; wl = '0; wr = '0;
    if (sclr) begin
      m_bits.delete();
      m_ql = '0; m_qr = '0; m_qv = 1'b0; m_ovf = 1'b0;
    end else begin
      if (rs) m_bits.delete();
      else if (en) begin
        m_bits.push_back(sin);
        if (m_bits.size() == W) begin
          for (int i = 0; i < W; i++) begin
            wl = wl + (8'(m_bits[i]) << (W - 1 - i));
            wr = wr + (8'(m_bits[i]) << i);
          end
          done = 1'b1;
          m_bits.delete();
        end
      end
      if (oc) m_ovf = 1'b0;
      if (done) begin
        if (!m_qv || rdy) begin m_ql = wl; m_qr = wr; m_qv = 1'b1; end
        else m_ovf = 1'b1;
      end else if (m_qv && rdy) m_qv = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (checking) begin
      chk("model q_left",     32'(bl.q), 32'(m_ql));
      chk("model q_right",    32'(br.q), 32'(m_qr));
      chk("model valid_l",    32'(bl.q_valid), 32'(m_qv));
      chk("model valid_r",    32'(br.q_valid), 32'(m_qv));
      chk("model ovf_l",      32'(bl.overflow), 32'(m_ovf));
      chk("model ovf_r",      32'(br.overflow), 32'(m_ovf));
      chk("model count_l",    32'(bl.bit_count), 32'(m_bits.size()));
      chk("model count_r",    32'(br.bit_count), 32'(m_bits.size()));
    end
  end

  task automatic step(input bit e, input bit b, input bit r, input bit rd, input bit o, input bit s);
    en = e; sin = b; rs = r; rdy = rd; oc = o; sclr = s;
    @(posedge clock);
    #1;
    en = 1'b0; sin = 1'b0; rs = 1'b0; rdy = 1'b0; oc = 1'b0; sclr = 1'b0;
  endtask

  // MSB of v sent first; gap inserts idle cycles between bits.
  task automatic send_byte(input logic [7:0] v, input bit gap, input bit rdy_last, input bit oc_last);
    for (int i = W - 1; i >= 0; i--) begin
      step(1'b1, v[i], 1'b0, (i == 0) && rdy_last, (i == 0) && oc_last, 1'b0);
      if (gap && i != 0) begin step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); end
    end
  endtask

  initial begin
    @(negedge clock);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checking = 1'b1;
    chk("reset q", 32'(bl.q), 32'h0);
    chk("reset valid", 32'(bl.q_valid), 32'h0);
    chk("reset ovf", 32'(bl.overflow), 32'h0);
    chk("reset count", 32'(bl.bit_count), 32'h0);

    // 1,0,1,1,0,0,1,0
    for (int i = 7; i >= 1; i--) begin
      step(1'b1, 8'hB2 >> i, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("count step", 32'(bl.bit_count), 32'(8 - i));
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("word left B2", 32'(bl.q), 32'hB2);
    chk("word right 4D", 32'(br.q), 32'h4D);
    chk("valid after 8", 32'(bl.q_valid), 32'h1);
    chk("count wrap", 32'(bl.bit_count), 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("read clears valid", 32'(br.q_valid), 32'h0);
    chk("read keeps q", 32'(br.q), 32'h4D);

    // Overflow on second unread word.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    send_byte(8'hA5, 1'b0, 1'b0, 1'b0);
    send_byte(8'h3C, 1'b0, 1'b0, 1'b0);
    chk("ovf keeps first", 32'(bl.q), 32'hA5);
    chk("ovf set", 32'(bl.overflow), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("ovf cleared", 32'(bl.overflow), 32'h0);
    chk("ovf clr keeps q", 32'(bl.q), 32'hA5);

    // Read on the completion edge: new word loads, no drop.
    send_byte(8'h3C, 1'b0, 1'b1, 1'b0);
    chk("simul q", 32'(bl.q), 32'h3C);
    chk("simul valid", 32'(bl.q_valid), 32'h1);
    chk("simul ovf", 32'(bl.overflow), 32'h0);

    // Restart mid-word; the bit sent with restart is discarded.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("restart count", 32'(bl.bit_count), 32'h0);
    send_byte(8'hF0, 1'b0, 1'b0, 1'b0);
    chk("restart word", 32'(bl.q), 32'hF0);

    // sclr with a held word and bits in flight.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    send_byte(8'h55, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, i[0], 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("sclr q", 32'(bl.q), 32'h0);
    chk("sclr valid", 32'(bl.q_valid), 32'h0);
    chk("sclr ovf", 32'(bl.overflow), 32'h0);
    chk("sclr count", 32'(bl.bit_count), 32'h0);
    send_byte(8'h96, 1'b1, 1'b0, 1'b0);
    chk("post sclr gapped word", 32'(bl.q), 32'h96);
    chk("post sclr right", 32'(br.q), 32'h69);

    // Drop and ovf_clr on the same edge: the set wins.
    send_byte(8'hC3, 1'b0, 1'b0, 1'b1);
    chk("drop beats clr", 32'(bl.overflow), 32'h1);
    chk("drop keeps q", 32'(bl.q), 32'h96);

    @(negedge clock);
    checking = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
